// File: rtl/hx8352_cmd_sequencer.sv
// hx8352_cmd_sequencer
// Walks a fixed HX8352-A initialisation ROM of command, data, delay and end
// entries, one word per bus-controller handshake. It then issues the
// memory-write command followed by H_RES*V_RES pixels of the latched fill
// colour.
// Optional feature: define HX8352_SEQ_TIMEOUT_EN to abort a handshake that
// stalls for 256 cycles and raise a sticky error flag.
module hx8352_cmd_sequencer #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned H_RES  = 240,
  parameter int unsigned V_RES  = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] fill_color,
  input  logic        busy,
  output logic [15:0] data_output,
  output logic        data_command,
  output logic        transfer_step,
  output logic        init_done,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, DELAY, FILL_CMD, FILL
  } state_t;

  // What the word currently in flight belongs to.
  typedef enum logic [1:0] {M_INIT, M_CMD, M_PIX} mode_t;

  typedef enum logic [1:0] {
    T_CMD = 2'b00, T_DATA = 2'b01, T_DELAY = 2'b10, T_END = 2'b11
  } entry_t;

  localparam logic [31:0] TICK     = 32'(CLK_HZ / 1000);
  localparam logic [16:0] PIX_LAST = 17'(H_RES * V_RES - 1);
  localparam logic [15:0] H_END    = 16'(H_RES - 1);
  localparam logic [15:0] V_END    = 16'(V_RES - 1);

  function automatic logic [17:0] ent_cmd(input logic [15:0] v);
    return {T_CMD, v};
  endfunction

  function automatic logic [17:0] ent_dat(input logic [15:0] v);
    return {T_DATA, v};
  endfunction

  function automatic logic [17:0] ent_dly(input logic [15:0] v);
    return {T_DELAY, v};
  endfunction

  // NOTE: the table is a constant function of the index, so it synthesises
  // to combinational logic and has no storage that would need a reset.
  function automatic logic [17:0] rom_entry(input logic [5:0] idx);
    case (idx)
      6'd0:  return ent_cmd(16'h0083);            // test mode on
      6'd1:  return ent_dat(16'h0002);
      6'd2:  return ent_dly(16'd5);
      6'd3:  return ent_cmd(16'h0085);            // VDC select
      6'd4:  return ent_dat(16'h0003);
      6'd5:  return ent_cmd(16'h008B);
      6'd6:  return ent_dat(16'h0001);
      6'd7:  return ent_cmd(16'h008C);            // standby bias
      6'd8:  return ent_dat(16'h0093);
      6'd9:  return ent_cmd(16'h0091);            // DC/DC sync
      6'd10: return ent_dat(16'h0001);
      6'd11: return ent_cmd(16'h0083);            // test mode off
      6'd12: return ent_dat(16'h0000);
      6'd13: return ent_cmd(16'h001A);            // booster ratio
      6'd14: return ent_dat(16'h0004);
      6'd15: return ent_cmd(16'h001B);            // VREG1 level
      6'd16: return ent_dat(16'h001C);
      6'd17: return ent_cmd(16'h0023);            // VCOM offset
      6'd18: return ent_dat(16'h0094);
      6'd19: return ent_cmd(16'h0024);            // VCOMH
      6'd20: return ent_dat(16'h0069);
      6'd21: return ent_cmd(16'h0025);            // VCOML
      6'd22: return ent_dat(16'h0063);
      6'd23: return ent_cmd(16'h0019);            // oscillator on
      6'd24: return ent_dat(16'h0001);
      6'd25: return ent_dly(16'd10);
      6'd26: return ent_cmd(16'h001F);            // power-up ramp
      6'd27: return ent_dat(16'h0088);
      6'd28: return ent_dly(16'd5);
      6'd29: return ent_cmd(16'h001F);
      6'd30: return ent_dat(16'h0080);
      6'd31: return ent_dly(16'd5);
      6'd32: return ent_cmd(16'h001F);
      6'd33: return ent_dat(16'h0090);
      6'd34: return ent_dly(16'd5);
      6'd35: return ent_cmd(16'h001F);
      6'd36: return ent_dat(16'h00D4);
      6'd37: return ent_dly(16'd5);
      6'd38: return ent_cmd(16'h0028);            // display gate on
      6'd39: return ent_dat(16'h0038);
      6'd40: return ent_dly(16'd40);
      6'd41: return ent_cmd(16'h0028);            // display on
      6'd42: return ent_dat(16'h003C);
      6'd43: return ent_cmd(16'h0002);            // column start
      6'd44: return ent_dat(16'h0000);
      6'd45: return ent_cmd(16'h0003);
      6'd46: return ent_dat(16'h0000);
      6'd47: return ent_cmd(16'h0004);            // column end
      6'd48: return ent_dat({8'h00, H_END[15:8]});
      6'd49: return ent_cmd(16'h0005);
      6'd50: return ent_dat({8'h00, H_END[7:0]});
      6'd51: return ent_cmd(16'h0006);            // row start
      6'd52: return ent_dat(16'h0000);
      6'd53: return ent_cmd(16'h0007);
      6'd54: return ent_dat(16'h0000);
      6'd55: return ent_cmd(16'h0008);            // row end
      6'd56: return ent_dat({8'h00, V_END[15:8]});
      6'd57: return ent_cmd(16'h0009);
      6'd58: return ent_dat({8'h00, V_END[7:0]});
      default: return {T_END, 16'h0000};
    endcase
  endfunction

  state_t      state, state_d;
  mode_t       mode;
  logic [5:0]  rom_idx;
  logic [31:0] dly_cnt;
  logic [16:0] pix_cnt;
  logic [15:0] fill_q;
  logic [17:0] entry;
  logic        accept;
  logic        wait_met;
  logic        dly_done;
  logic        pix_last;
  logic        timeout;

  assign entry         = rom_entry(rom_idx);
  assign accept        = start && !busy;
  assign wait_met      = (state == WAIT_HI && busy) || (state == WAIT_LO && !busy);
  assign dly_done      = (dly_cnt <= 32'd1);
  assign pix_last      = (pix_cnt == PIX_LAST);
  assign transfer_step = (state == ISSUE);

  // State register.
  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state decode; a handshake timeout overrides every other transition.
  // NOTE: state_d gets its default before the case so that no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (accept) state_d = init_done ? FILL_CMD : FETCH;
      FETCH: begin
        case (entry[17:16])
          T_CMD, T_DATA: state_d = ISSUE;
          T_DELAY:       state_d = DELAY;
          T_END:         state_d = FILL_CMD;
          default:       state_d = FILL_CMD;
        endcase
      end
      ISSUE:    state_d = WAIT_HI;
      WAIT_HI:  if (wait_met) state_d = WAIT_LO;
      WAIT_LO: begin
        if (wait_met) begin
          if (mode == M_INIT)                state_d = FETCH;
          else if (mode == M_PIX && pix_last) state_d = IDLE;
          else                               state_d = FILL;
        end
      end
      DELAY:    if (dly_done) state_d = FETCH;
      FILL_CMD: state_d = ISSUE;
      FILL:     state_d = ISSUE;
      default:  state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // Datapath: ROM index, delay and pixel counters, output word and flags.
  // The output word is loaded only in FETCH/FILL_CMD/FILL, so it is held
  // throughout ISSUE and both wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode         <= M_INIT;
      rom_idx      <= '0;
      dly_cnt      <= '0;
      pix_cnt      <= '0;
      fill_q       <= '0;
      data_output  <= '0;
      data_command <= 1'b0;
      init_done    <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            fill_q <= fill_color;
            if (!init_done) begin
              rom_idx <= '0;
              mode    <= M_INIT;
            end
          end
        end
        FETCH: begin
          case (entry[17:16])
            T_CMD, T_DATA: begin
              data_output  <= entry[15:0];
              data_command <= entry[16];
            end
            T_DELAY: dly_cnt <= 32'(entry[15:0]) * TICK;
            default: init_done <= 1'b1;
          endcase
        end
        DELAY: begin
          if (dly_done) rom_idx <= rom_idx + 6'd1;
          else          dly_cnt <= dly_cnt - 32'd1;
        end
        FILL_CMD: begin
          data_output  <= 16'h0022;
          data_command <= 1'b0;
          pix_cnt      <= '0;
          mode         <= M_CMD;
        end
        FILL: begin
          data_output  <= fill_q;
          data_command <= 1'b1;
        end
        WAIT_LO: begin
          if (wait_met) begin
            case (mode)
              M_INIT: rom_idx <= rom_idx + 6'd1;
              M_CMD:  mode    <= M_PIX;
              default: begin
                if (pix_last) done    <= 1'b1;
                else          pix_cnt <= pix_cnt + 17'd1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HX8352_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       error_q;
  logic       waiting;

  assign waiting = (state == WAIT_HI) || (state == WAIT_LO);
  assign timeout = waiting && !wait_met && (wait_cnt == 8'hFF);
  assign error   = error_q;

  // Counts cycles spent in the current wait state; the error flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      wait_cnt <= (waiting && !wait_met) ? wait_cnt + 8'd1 : 8'd0;
      if (timeout) error_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_hx8352_cmd_sequencer.sv
// tb_hx8352_cmd_sequencer
// Directed bench for hx8352_cmd_sequencer with a small bus-controller
// responder (busy high for three cycles after each transfer_step) and a
// monitor that logs every transfer and checks step width and word stability.
`timescale 1ns/1ps
module tb_hx8352_cmd_sequencer;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned H_RES    = 2;
  localparam int unsigned V_RES    = 2;
  localparam int          BUSY_LEN = 3;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        dc;
    logic        ini;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] fill_color = '0;
  logic        busy;
  logic [15:0] data_output;
  logic        data_command;
  logic        transfer_step;
  logic        init_done;
  logic        done;
  logic        error;

  logic        force_busy = 1'b0;
  logic        stuck = 1'b0;
  int          busy_cnt = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          hold_left = 0;
  logic [15:0] hold_d = '0;
  logic        hold_dc = 1'b0;
  logic        step_prev = 1'b0;
  xfer_t       xq[$];

  int n_cmp = 0;
  int n_fail = 0;

  hx8352_cmd_sequencer #(
    .CLK_HZ(CLK_HZ),
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .fill_color   (fill_color),
    .busy         (busy),
    .data_output  (data_output),
    .data_command (data_command),
    .transfer_step(transfer_step),
    .init_done    (init_done),
    .done         (done),
    .error        (error)
  );

  always #10 clk = ~clk;

  assign busy = force_busy || (busy_cnt > 0);

  // Responder and protocol monitor, evaluated between rising edges.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      busy_cnt  = 0;
      hold_left = 0;
      step_prev = 1'b0;
    end else begin
      if (transfer_step) begin
        n_cmp++;
        assert (step_prev === 1'b0) else begin
          n_fail++;
          $error("FAIL step_width at cyc %0d: observed >1 cycle, expected 1 cycle", cyc);
        end
        if (!step_prev) begin
          xq.push_back('{cyc, data_output, data_command, init_done});
          hold_d    = data_output;
          hold_dc   = data_command;
          hold_left = BUSY_LEN + 1;
        end
      end else if (hold_left > 0) begin
        n_cmp++;
        assert (data_output === hold_d && data_command === hold_dc) else begin
          n_fail++;
          $error("FAIL word_hold at cyc %0d: observed %h/%b, expected %h/%b",
                 cyc, data_output, data_command, hold_d, hold_dc);
        end
        hold_left--;
      end
      if (transfer_step && !stuck) busy_cnt = BUSY_LEN;
      else if (busy_cnt > 0)       busy_cnt--;
      if (done) done_cnt++;
      step_prev = transfer_step;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
  endtask

  task automatic wait_xfer(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (xq.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_data_output"},   32'(data_output), 32'h0);
    check({pfx, "_data_command"},  32'(data_command), 32'h0);
    check({pfx, "_transfer_step"}, 32'(transfer_step), 32'h0);
    check({pfx, "_init_done"},     32'(init_done), 32'h0);
    check({pfx, "_done"},          32'(done), 32'h0);
    check({pfx, "_error"},         32'(error), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int n22;

    // Reset state.
    #1 rst = 1'b0;
    repeat (3) tick();
    check_reset("por");

    // Busy high out of the controller's reset blocks start.
    force_busy = 1'b1;
    start      = 1'b1;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("busy_blocks_start_after_reset", 32'(xq.size()), 32'd0);
    start = 1'b0;
    tick();
    force_busy = 1'b0;
    tick();

    // Run A: init then fill, start held high; fill_color changed mid-run.
    xq.delete();
    done_cnt   = 0;
    fill_color = 16'hF800;
    start      = 1'b1;
    repeat (3) tick();
    fill_color = 16'h07E0;
    wait_done(3000, ok);
    start = 1'b0;
    check("runA_done_seen", 32'(ok), 32'd1);
    n = xq.size();
    repeat (10) tick();
    check("runA_no_restart", 32'(xq.size()), 32'(n));
    check("runA_done_pulses", 32'(done_cnt), 32'd1);
    check("runA_init_done", 32'(init_done), 32'd1);
    check("runA_enough_words", 32'(n >= 8), 32'd1);
    if (n >= 8) begin
      check("runA_w0_data", 32'(xq[0].d), 32'h0083);
      check("runA_w0_rs",   32'(xq[0].dc), 32'd0);
      check("runA_w1_data", 32'(xq[1].d), 32'h0002);
      check("runA_w1_rs",   32'(xq[1].dc), 32'd1);
      check("runA_w2_data", 32'(xq[2].d), 32'h0085);
      check("runA_w2_rs",   32'(xq[2].dc), 32'd0);
      // Plain word-to-word period: 5 cycles.
      check("runA_gap_w0_w1", 32'(xq[1].cyc - xq[0].cyc), 32'd5);
      // Delay entry adds its fetch cycle plus 5 one-cycle ms ticks.
      check("runA_gap_w1_w2", 32'(xq[2].cyc - xq[1].cyc), 32'd5 + 32'd1 + 32'd5);
      check("runA_last_rom_init_done", 32'(xq[n-6].ini), 32'd0);
      check("runA_cmd22_data", 32'(xq[n-5].d), 32'h0022);
      check("runA_cmd22_rs",   32'(xq[n-5].dc), 32'd0);
      check("runA_cmd22_init_done", 32'(xq[n-5].ini), 32'd1);
      for (int i = n - 4; i < n; i++) begin
        check("runA_fill_data", 32'(xq[i].d), 32'hF800);
        check("runA_fill_rs",   32'(xq[i].dc), 32'd1);
      end
      n22 = 0;
      for (int i = 0; i < n; i++) if (xq[i].d == 16'h0022 && xq[i].dc == 1'b0) n22++;
      check("runA_single_cmd22", 32'(n22), 32'd1);
    end

    // Start while busy is high in IDLE is ignored and not queued.
    force_busy = 1'b1;
    tick();
    start = 1'b1;
    repeat (8) tick();
    start = 1'b0;
    tick();
    force_busy = 1'b0;
    repeat (10) tick();
    check("busy_ignores_start", 32'(xq.size()), 32'(n));

    // Run B: fill only, with init already done.
    xq.delete();
    done_cnt   = 0;
    fill_color = 16'hF800;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, ok);
    check("runB_done_seen", 32'(ok), 32'd1);
    repeat (5) tick();
    check("runB_word_count", 32'(xq.size()), 32'd5);
    check("runB_done_pulses", 32'(done_cnt), 32'd1);
    if (xq.size() == 5) begin
      check("runB_cmd22_data", 32'(xq[0].d), 32'h0022);
      check("runB_cmd22_rs",   32'(xq[0].dc), 32'd0);
      for (int i = 1; i < 5; i++) begin
        check("runB_fill_data", 32'(xq[i].d), 32'hF800);
        check("runB_fill_rs",   32'(xq[i].dc), 32'd1);
      end
      check("runB_gap", 32'(xq[1].cyc - xq[0].cyc), 32'd5);
    end

    // Reset during WAIT_LO of the second fill word.
    xq.delete();
    done_cnt   = 0;
    fill_color = 16'h001F;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_xfer(3, 100, ok);
    check("rstmid_reached_word", 32'(ok), 32'd1);
    tick();
    tick();
    check("rstmid_busy_in_wait_lo", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    check_reset("rstmid");
    rst = 1'b1;
    tick();
    xq.delete();
    done_cnt = 0;
    start    = 1'b1;
    wait_xfer(1, 50, ok);
    start = 1'b0;
    check("rstmid_restart_seen", 32'(ok), 32'd1);
    if (ok) begin
      check("rstmid_restart_data", 32'(xq[0].d), 32'h0083);
      check("rstmid_restart_rs",   32'(xq[0].dc), 32'd0);
    end
    wait_done(3000, ok);
    check("rstmid_rerun_done", 32'(ok), 32'd1);
    repeat (3) tick();

    // Busy never rises after ISSUE.
    stuck = 1'b1;
    xq.delete();
    done_cnt = 0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    check("stuck_word_count", 32'(xq.size()), 32'd1);
    check("stuck_no_done", 32'(done_cnt), 32'd0);
`ifdef HX8352_SEQ_TIMEOUT_EN
    check("stuck_error_set", 32'(error), 32'd1);
    stuck = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_xfer(2, 20, ok);
    check("stuck_back_in_idle", 32'(ok), 32'd1);
    wait_done(200, ok);
    check("stuck_error_sticky", 32'(error), 32'd1);
`else
    check("stuck_error_zero", 32'(error), 32'd0);
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    check("stuck_stalled", 32'(xq.size()), 32'd1);
    check("stuck_step_low", 32'(transfer_step), 32'd0);
`endif
    stuck = 1'b0;
    rst   = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
